// File: rtl/piso_serial_tx.sv
// Parallel-in/serial-out transmitter: one WIDTH-bit word per frame, one bit per clock, with frame qualifiers.
// Latency: word accepted at edge k puts bit 0 on ser_out in cycle k+1; frames chain with no idle gap.
// Backpressure: load_ready only in IDLE or the last-bit cycle; abort beats a same-edge load.
module piso_serial_tx #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             abort,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_IDX   = CW'(WIDTH - 1);
    localparam logic [CW-1:0] PENULT_IDX = CW'(WIDTH - 2);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] shift_reg;
    logic             last_bit;
    logic             load_acc;
    logic             first_bit;
    logic             next_bit;
    logic [WIDTH-1:0] data_rest;
    logic [WIDTH-1:0] shift_rest;

    assign last_bit = (state == SHIFT) && (bit_cnt == LAST_IDX);
    assign load_acc = load_valid && load_ready && !abort;

    // shift_reg holds only the bits not yet driven onto ser_out
    assign first_bit  = LSB_FIRST ? data_in[0] : data_in[WIDTH-1];
    assign next_bit   = LSB_FIRST ? shift_reg[0] : shift_reg[WIDTH-1];
    assign data_rest  = LSB_FIRST ? {1'b0, data_in[WIDTH-1:1]} : {data_in[WIDTH-2:0], 1'b0};
    assign shift_rest = LSB_FIRST ? {1'b0, shift_reg[WIDTH-1:1]} : {shift_reg[WIDTH-2:0], 1'b0};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (load_acc) state_nxt = SHIFT;
                SHIFT:   if (last_bit && !load_acc) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        load_ready = (state == IDLE) || last_bit;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_reg   <= '0;
            bit_cnt     <= '0;
            ser_out     <= 1'b0;
            ser_valid   <= 1'b0;
            frame_start <= 1'b0;
            done        <= 1'b0;
        end else if (abort) begin
            ser_out     <= 1'b0;
            ser_valid   <= 1'b0;
            frame_start <= 1'b0;
            done        <= 1'b0;
        end else if (load_acc) begin
            shift_reg   <= data_rest;
            bit_cnt     <= '0;
            ser_out     <= first_bit;
            ser_valid   <= 1'b1;
            frame_start <= 1'b1;
            done        <= 1'b0;
        end else if ((state == SHIFT) && !last_bit) begin
            shift_reg   <= shift_rest;
            bit_cnt     <= bit_cnt + 1'b1;
            ser_out     <= next_bit;
            ser_valid   <= 1'b1;
            frame_start <= 1'b0;
            done        <= (bit_cnt == PENULT_IDX);
        end else begin
            ser_out     <= 1'b0;
            ser_valid   <= 1'b0;
            frame_start <= 1'b0;
            done        <= 1'b0;
        end
    end

endmodule
